surf4_debug_mux: RTL and testbench

- Parametrised, Wishbone-controlled debug multiplexer that selects one of NCH debug buses for an ILA trigger port.
- Adds a mask/value trigger comparator, a match counter and an armed one-shot snapshot, all readable over Wishbone.
- Sits between the per-subsystem debug buses and the ILA input.
- Configured from the VIO-driven Wishbone bridge, so channel select and trigger setup need no rebuild.

---
 rtl/surf4_debug_mux_pkg.sv | 24 ++
 rtl/surf4_debug_mux_trig.sv | 57 +++++
 rtl/surf4_debug_mux.sv | 160 ++++++++++++++++
 tb/tb_surf4_debug_mux.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/surf4_debug_mux_pkg.sv
// Shared register map and CTRL bit positions for surf4_debug_mux.
// Bridge software and the bench use the same constants.
package surf4_debug_mux_pkg;

    localparam logic [3:0] ADR_SEL    = 4'd0;
    localparam logic [3:0] ADR_CTRL   = 4'd1;
    localparam logic [3:0] ADR_MASK   = 4'd2;
    localparam logic [3:0] ADR_VALUE  = 4'd3;
    localparam logic [3:0] ADR_COUNT  = 4'd4;
    localparam logic [3:0] ADR_SNAP   = 4'd5;
    localparam logic [3:0] ADR_TSTAMP = 4'd6;

    localparam int unsigned CTRL_FREEZE = 0;
    localparam int unsigned CTRL_LEVEL  = 1;
    localparam int unsigned CTRL_ARM    = 2;
    localparam int unsigned CTRL_DONE   = 3;

    typedef enum logic [1:0] {
        WB_IDLE,
        WB_ACK,
        WB_ERR
    } wb_state_e;

endpackage

// File: rtl/surf4_debug_mux_trig.sv
// surf4_debug_trig: mask/value comparator, match edge detect, saturating
// match counter and armed one-shot snapshot.
module surf4_debug_trig #(
    parameter int unsigned DBG_WIDTH = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [DBG_WIDTH-1:0] dbg_nxt_i,
    input  logic [DBG_WIDTH-1:0] dbg_q_i,
    input  logic [DBG_WIDTH-1:0] mask_i,
    input  logic [DBG_WIDTH-1:0] value_i,
    input  logic                 level_i,
    input  logic                 arm_set_i,
    input  logic                 cnt_clr_i,
    output logic                 match_o,
    output logic [31:0]          count_o,
    output logic [DBG_WIDTH-1:0] snap_o,
    output logic                 arm_o,
    output logic                 done_o,
    output logic                 capture_o
);

    logic match_d1;
    logic inc;

    assign inc       = level_i ? match_o : (match_o & ~match_d1);
    // An arm write in the same cycle as a match defers capture to the next match.
    assign capture_o = arm_o & match_o & ~arm_set_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            match_o  <= 1'b0;
            match_d1 <= 1'b0;
            count_o  <= '0;
            snap_o   <= '0;
            arm_o    <= 1'b0;
            done_o   <= 1'b0;
        end else begin
            match_o  <= ((dbg_nxt_i ^ value_i) & mask_i) == '0;
            match_d1 <= match_o;
            if (cnt_clr_i) begin
                count_o <= '0;
            end else if (inc && count_o != '1) begin
                count_o <= count_o + 32'd1;
            end
            if (arm_set_i) begin
                arm_o  <= 1'b1;
                done_o <= 1'b0;
            end else if (capture_o) begin
                arm_o  <= 1'b0;
                done_o <= 1'b1;
                snap_o <= dbg_q_i;
            end
        end
    end

endmodule

// File: rtl/surf4_debug_mux.sv
// Wishbone-controlled debug bus selector with trigger, counter and snapshot.
// Optional cycle timestamp on capture: define SURF4_DEBUG_MUX_TIMESTAMP_EN.
module surf4_debug_mux
    import surf4_debug_mux_pkg::*;
#(
    parameter int unsigned NCH       = 4,
    parameter int unsigned DBG_WIDTH = 32,
    parameter int unsigned SEL_BITS  = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     cyc_i,
    input  logic                     stb_i,
    input  logic                     we_i,
    input  logic [3:0]               adr_i,
    input  logic [31:0]              dat_i,
    output logic [31:0]              dat_o,
    output logic                     ack_o,
    output logic                     err_o,
    output logic                     rty_o,
    input  logic [NCH*DBG_WIDTH-1:0] debug_i,
    output logic [DBG_WIDTH-1:0]     debug_o,
    output logic                     match_o,
    output logic                     snap_done_o
);

    wb_state_e             state_q, state_d;
    logic [SEL_BITS-1:0]   sel_q;
    logic                  freeze_q, level_q;
    logic [DBG_WIDTH-1:0]  mask_q, value_q;
    logic [DBG_WIDTH-1:0]  chan, nxt;
    logic [31:0]           rd_data, dat_d;
    logic                  wr_sel, wr_ctrl, wr_mask, wr_value, cnt_clr, arm_set;
    logic [31:0]           count;
    logic [DBG_WIDTH-1:0]  snap;
    logic                  arm, capture;
`ifdef SURF4_DEBUG_MUX_TIMESTAMP_EN
    logic [31:0]           tstamp_cnt, tstamp_q;
`endif

    assign rty_o = 1'b0;
    assign ack_o = (state_q == WB_ACK);
    assign err_o = (state_q == WB_ERR);

    always_comb begin
        chan = '0;
        for (int unsigned k = 0; k < NCH; k++) begin
            if (sel_q == SEL_BITS'(k)) chan = debug_i[k*DBG_WIDTH +: DBG_WIDTH];
        end
    end

    assign nxt = freeze_q ? debug_o : chan;

    // Request is sampled only while idle, so every response blocks one cycle.
    always_comb begin
        state_d  = WB_IDLE;
        rd_data  = '0;
        wr_sel   = 1'b0;
        wr_ctrl  = 1'b0;
        wr_mask  = 1'b0;
        wr_value = 1'b0;
        cnt_clr  = 1'b0;
        if (cyc_i && stb_i && state_q == WB_IDLE) begin
            state_d = WB_ACK;
            case (adr_i)
                ADR_SEL: begin
                    rd_data = 32'(sel_q);
                    if (we_i) begin
                        if (dat_i >= 32'(NCH)) state_d = WB_ERR;
                        else                   wr_sel  = 1'b1;
                    end
                end
                ADR_CTRL: begin
                    rd_data[CTRL_FREEZE] = freeze_q;
                    rd_data[CTRL_LEVEL]  = level_q;
                    rd_data[CTRL_ARM]    = arm;
                    rd_data[CTRL_DONE]   = snap_done_o;
                    wr_ctrl = we_i;
                end
                ADR_MASK: begin
                    rd_data = 32'(mask_q);
                    wr_mask = we_i;
                end
                ADR_VALUE: begin
                    rd_data  = 32'(value_q);
                    wr_value = we_i;
                end
                ADR_COUNT: begin
                    rd_data = count;
                    cnt_clr = we_i;
                end
                ADR_SNAP:   rd_data = 32'(snap);
`ifdef SURF4_DEBUG_MUX_TIMESTAMP_EN
                ADR_TSTAMP: rd_data = tstamp_q;
`endif
                default:    state_d = WB_ERR;
            endcase
        end
    end

    assign dat_d   = (state_d == WB_ACK && !we_i) ? rd_data : '0;
    assign arm_set = wr_ctrl & dat_i[CTRL_ARM];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= WB_IDLE;
            dat_o    <= '0;
            sel_q    <= '0;
            freeze_q <= 1'b0;
            level_q  <= 1'b0;
            mask_q   <= '0;
            value_q  <= '0;
            debug_o  <= '0;
        end else begin
            state_q <= state_d;
            dat_o   <= dat_d;
            debug_o <= nxt;
            if (wr_sel)   sel_q   <= dat_i[SEL_BITS-1:0];
            if (wr_mask)  mask_q  <= DBG_WIDTH'(dat_i);
            if (wr_value) value_q <= DBG_WIDTH'(dat_i);
            if (wr_ctrl) begin
                freeze_q <= dat_i[CTRL_FREEZE];
                level_q  <= dat_i[CTRL_LEVEL];
            end
        end
    end

`ifdef SURF4_DEBUG_MUX_TIMESTAMP_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tstamp_cnt <= '0;
            tstamp_q   <= '0;
        end else begin
            tstamp_cnt <= tstamp_cnt + 32'd1;
            if (capture) tstamp_q <= tstamp_cnt;
        end
    end
`endif

    surf4_debug_trig #(
        .DBG_WIDTH (DBG_WIDTH)
    ) u_trig (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .dbg_nxt_i (nxt),
        .dbg_q_i   (debug_o),
        .mask_i    (mask_q),
        .value_i   (value_q),
        .level_i   (level_q),
        .arm_set_i (arm_set),
        .cnt_clr_i (cnt_clr),
        .match_o   (match_o),
        .count_o   (count),
        .snap_o    (snap),
        .arm_o     (arm),
        .done_o    (snap_done_o),
        .capture_o (capture)
    );

endmodule

// File: tb/tb_surf4_debug_mux.sv
// Self-checking bench for surf4_debug_mux: directed scenarios plus random
// Wishbone/debug traffic against a cycle-level reference model.
module tb_surf4_debug_mux;
    import surf4_debug_mux_pkg::*;

    localparam int NCH = 4;
    localparam int DW  = 32;

    logic              clk_i = 1'b0;
    logic              rst_i = 1'b0;
    logic              cyc_i = 1'b0, stb_i = 1'b0, we_i = 1'b0;
    logic [3:0]        adr_i = '0;
    logic [31:0]       dat_i = '0;
    logic [31:0]       dat_o;
    logic              ack_o, err_o, rty_o;
    logic [NCH*DW-1:0] debug_i = '0;
    logic [DW-1:0]     debug_o;
    logic              match_o, snap_done_o;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    int          m_sel;
    bit          m_freeze, m_level, m_arm, m_done, m_match, m_prev, m_ack, m_err;
    logic [31:0] m_mask, m_value, m_count, m_snap, m_dbg, m_dat, m_tstamp, m_cycles;

    logic [31:0] rdata;
    bit          rerr;

    surf4_debug_mux #(
        .NCH       (NCH),
        .DBG_WIDTH (DW),
        .SEL_BITS  (4)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .cyc_i       (cyc_i),
        .stb_i       (stb_i),
        .we_i        (we_i),
        .adr_i       (adr_i),
        .dat_i       (dat_i),
        .dat_o       (dat_o),
        .ack_o       (ack_o),
        .err_o       (err_o),
        .rty_o       (rty_o),
        .debug_i     (debug_i),
        .debug_o     (debug_o),
        .match_o     (match_o),
        .snap_done_o (snap_done_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit adr_ok(input logic [3:0] a);
`ifdef SURF4_DEBUG_MUX_TIMESTAMP_EN
        return a <= 4'd6;
`else
        return a <= 4'd5;
`endif
    endfunction

    function automatic logic [31:0] reg_val(input logic [3:0] a);
        case (a)
            ADR_SEL:    return 32'(m_sel);
            ADR_CTRL:   return {28'd0, m_done, m_arm, m_level, m_freeze};
            ADR_MASK:   return m_mask;
            ADR_VALUE:  return m_value;
            ADR_COUNT:  return m_count;
            ADR_SNAP:   return m_snap;
            default:    return m_tstamp;
        endcase
    endfunction

    task automatic model_reset();
        m_sel = 0; m_freeze = 0; m_level = 0; m_arm = 0; m_done = 0;
        m_match = 0; m_prev = 0; m_ack = 0; m_err = 0;
        m_mask = 0; m_value = 0; m_count = 0; m_snap = 0; m_dbg = 0;
        m_dat = 0; m_tstamp = 0; m_cycles = 0;
    endtask

    // One clock edge of the specified behaviour, evaluated from pre-edge state.
    task automatic model_step();
        logic [31:0] nxt, old_dbg, rd;
        bit req, ok, inc, cap, arm_wr, clr, old_match;
        req       = cyc_i && stb_i && !m_ack && !m_err;
        old_dbg   = m_dbg;
        old_match = m_match;
        nxt       = m_freeze ? m_dbg : debug_i[m_sel*DW +: DW];
        inc       = m_level ? old_match : (old_match && !m_prev);
        cap       = m_arm && old_match;
        ok        = req && adr_ok(adr_i) && !(we_i && adr_i == ADR_SEL && dat_i >= NCH);
        rd        = (ok && !we_i) ? reg_val(adr_i) : 32'd0;
        arm_wr    = ok && we_i && adr_i == ADR_CTRL && dat_i[CTRL_ARM];
        clr       = ok && we_i && adr_i == ADR_COUNT;

        m_prev  = old_match;
        m_dbg   = nxt;
        m_match = ((nxt ^ m_value) & m_mask) == 0;
        if (clr) m_count = 0;
        else if (inc && m_count != 32'hFFFF_FFFF) m_count = m_count + 1;
        if (arm_wr) begin
            m_arm = 1; m_done = 0;
        end else if (cap) begin
            m_arm = 0; m_done = 1; m_snap = old_dbg; m_tstamp = m_cycles;
        end
        if (ok && we_i) begin
            case (adr_i)
                ADR_SEL:   m_sel = int'(dat_i);
                ADR_CTRL:  begin m_freeze = dat_i[CTRL_FREEZE]; m_level = dat_i[CTRL_LEVEL]; end
                ADR_MASK:  m_mask = dat_i;
                ADR_VALUE: m_value = dat_i;
                default:   ;
            endcase
        end
        m_cycles = m_cycles + 1;
        m_ack = ok;
        m_err = req && !ok;
        m_dat = rd;
    endtask

    task automatic compare_all();
        check("debug_o", debug_o, m_dbg);
        check("match_o", match_o, m_match);
        check("snap_done_o", snap_done_o, m_done);
        check("ack_o", ack_o, m_ack);
        check("err_o", err_o, m_err);
        check("dat_o", dat_o, m_dat);
        check("rty_o", rty_o, 0);
    endtask

    task automatic tick();
        @(posedge clk_i);
        model_step();
        @(negedge clk_i);
        compare_all();
    endtask

    task automatic do_reset();
        cyc_i = 0; stb_i = 0; we_i = 0;
        rst_i = 1;
        model_reset();
        @(posedge clk_i);
        @(negedge clk_i);
        compare_all();
        rst_i = 0;
    endtask

    task automatic wb(input bit w, input logic [3:0] a, input logic [31:0] d,
                      output logic [31:0] rd, output bit e);
        bit got;
        got = 0;
        cyc_i = 1; stb_i = 1; we_i = w; adr_i = a; dat_i = d;
        for (int i = 0; i < 4 && !got; i++) begin
            tick();
            if (ack_o || err_o) got = 1;
        end
        rd = dat_o;
        e  = err_o;
        cyc_i = 0; stb_i = 0; we_i = 0;
        check("wb_response", 32'(got), 1);
    endtask

    task automatic set_ch(input int k, input logic [31:0] v);
        debug_i[k*DW +: DW] = v;
    endtask

    initial begin
        do_reset();
        check("reset_debug_o", debug_o, 0);
        check("reset_dat_o", dat_o, 0);

        // illegal select and unmapped address
        wb(1, ADR_SEL, 32'd4, rdata, rerr);
        check("sel4_err", 32'(rerr), 1);
        wb(0, ADR_SEL, 0, rdata, rerr);
        check("sel_after_err", rdata, 0);
        wb(0, 4'd9, 0, rdata, rerr);
        check("adr9_err", 32'(rerr), 1);

        // channel select
        set_ch(2, 32'hA5A5_0001);
        wb(1, ADR_SEL, 32'd2, rdata, rerr);
        check("sel2_ack", 32'(rerr), 0);
        tick();
        check("sel2_debug", debug_o, 32'hA5A5_0001);
        wb(0, ADR_SEL, 0, rdata, rerr);
        check("sel_readback", rdata, 32'd2);

        // edge counting
        set_ch(0, 32'h100);
        wb(1, ADR_SEL, 0, rdata, rerr);
        wb(1, ADR_MASK, 32'hFF, rdata, rerr);
        wb(1, ADR_VALUE, 32'h3C, rdata, rerr);
        wb(1, ADR_CTRL, 0, rdata, rerr);
        tick(); tick();
        wb(1, ADR_COUNT, 0, rdata, rerr);
        for (int i = 0; i < 5; i++) begin
            set_ch(0, 32'h13C); tick();
            set_ch(0, 32'h100); tick();
        end
        tick(); tick();
        wb(0, ADR_COUNT, 0, rdata, rerr);
        check("count_edges", rdata, 32'd5);

        // level counting
        wb(1, ADR_CTRL, 32'h2, rdata, rerr);
        wb(1, ADR_COUNT, 0, rdata, rerr);
        set_ch(0, 32'h3C);
        for (int i = 0; i < 10; i++) tick();
        set_ch(0, 32'h100);
        tick(); tick(); tick();
        wb(0, ADR_COUNT, 0, rdata, rerr);
        check("count_level", rdata, 32'd10);

        // clear while matching: one increment lands during the blocked cycle before the read
        set_ch(0, 32'h3C);
        tick(); tick();
        wb(1, ADR_COUNT, 0, rdata, rerr);
        wb(0, ADR_COUNT, 0, rdata, rerr);
        check("count_clear_wins", rdata, 32'd1);
        set_ch(0, 32'h100);
        tick(); tick();

        // one-shot snapshot
        wb(1, ADR_CTRL, 32'h4, rdata, rerr);
        set_ch(0, 32'h11);  tick();
        set_ch(0, 32'h3C);  tick();
        set_ch(0, 32'h13C); tick();
        set_ch(0, 32'h100); tick(); tick();
        wb(0, ADR_SNAP, 0, rdata, rerr);
        check("snap_value", rdata, 32'h3C);
        wb(0, ADR_CTRL, 0, rdata, rerr);
        check("ctrl_done", rdata, 32'h8);
        check("snap_done_o", snap_done_o, 1);

        // freeze
        set_ch(0, 32'h55);
        tick(); tick();
        wb(1, ADR_CTRL, 32'h1, rdata, rerr);
        for (int i = 0; i < 5; i++) begin
            set_ch(0, $urandom);
            tick();
            check("freeze_debug", debug_o, 32'h55);
            check("freeze_match", match_o, 0);
        end
        set_ch(0, 32'h77);
        wb(1, ADR_CTRL, 0, rdata, rerr);
        tick();
        check("unfreeze_debug", debug_o, 32'h77);

        // reset aborts an outstanding request
        @(negedge clk_i);
        cyc_i = 1; stb_i = 1; we_i = 0; adr_i = ADR_SEL;
        #2 rst_i = 1;
        model_reset();
        @(posedge clk_i);
        @(negedge clk_i);
        check("abort_no_ack", ack_o, 0);
        compare_all();
        cyc_i = 0; stb_i = 0;
        rst_i = 0;

`ifdef SURF4_DEBUG_MUX_TIMESTAMP_EN
        // MASK resets to 0, so the match is permanent and capture follows the arm
        for (int i = 0; i < 97; i++) tick();
        wb(1, ADR_CTRL, 32'h4, rdata, rerr);
        tick();
        wb(0, ADR_TSTAMP, 0, rdata, rerr);
        check("tstamp_value", rdata, m_tstamp);
        check("tstamp_err", 32'(rerr), 0);
`else
        wb(0, ADR_TSTAMP, 0, rdata, rerr);
        check("adr6_err", 32'(rerr), 1);
`endif

        // random traffic
        for (int n = 0; n < 300; n++) begin
            logic [3:0]  a;
            logic [31:0] d;
            for (int k = 0; k < NCH; k++) begin
                case ($urandom_range(0, 3))
                    0:       set_ch(k, 32'h3C);
                    1:       set_ch(k, 32'h13C);
                    default: set_ch(k, $urandom);
                endcase
            end
            for (int i = 0; i < int'($urandom_range(0, 2)); i++) tick();
            a = 4'($urandom_range(0, 9));
            case (a)
                ADR_SEL:   d = $urandom_range(0, 5);
                ADR_CTRL:  d = $urandom_range(0, 15);
                ADR_MASK:  d = ($urandom_range(0, 2) == 0) ? $urandom : 32'hFF;
                ADR_VALUE: d = ($urandom_range(0, 1) == 0) ? $urandom : 32'h3C;
                default:   d = $urandom;
            endcase
            wb(1'($urandom_range(0, 1)), a, d, rdata, rerr);
        end

        tick(); tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
